// File: rtl/rice_core_fetch_unit.sv
// rice_core_fetch_unit: in-order instruction fetch with credit-limited request issue
// and a small queue presenting {pc, inst} to decode.
module rice_core_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              QUEUE_DEPTH  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_inst_request_valid,
    input  logic            i_inst_request_ready,
    output logic [XLEN-1:0] o_inst_address,
    input  logic            i_inst_response_valid,
    input  logic [XLEN-1:0] i_inst_response_data,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_inst
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    // Discarded responses can pile up across back-to-back flushes, so this is wider than CW.
    localparam int DW = 8;
    typedef enum logic {REQ, WAIT} state_t;
    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding, count;
    logic [DW-1:0]   discard;
    logic [XLEN-1:0] q_pc [QUEUE_DEPTH];
    logic [XLEN-1:0] q_inst [QUEUE_DEPTH];
    logic [XLEN-1:0] tag [QUEUE_DEPTH];
    logic [AW-1:0]   q_head, q_tail, t_head, t_tail;
    logic            credit, ack, push, pop;
    assign credit = (int'(outstanding) + int'(count)) < QUEUE_DEPTH;
    assign ack    = o_inst_request_valid && i_inst_request_ready;
    assign push   = i_inst_response_valid && discard == '0 && !i_flush;
    assign pop    = count != '0 && !i_stall && !i_flush;
    assign o_inst_address = fetch_pc;
    assign o_if_valid     = count != '0;
    assign o_if_pc        = q_pc[q_head];
    assign o_if_inst      = q_inst[q_head];
    always_comb begin
        o_inst_request_valid = !i_rst && !i_flush && (state == WAIT || credit);
        state_next = state;
        if (i_flush)
            state_next = REQ;
        else if (state == REQ && o_inst_request_valid && !i_inst_request_ready)
            state_next = WAIT;
        else if (state == WAIT && ack)
            state_next = REQ;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= REQ;
            fetch_pc    <= RESET_VECTOR;
            outstanding <= '0;
            count       <= '0;
            discard     <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            t_head      <= '0;
            t_tail      <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
                tag[i]    <= '0;
            end
        end else begin
            state <= state_next;
            if (i_flush) begin
                // Every request still on the bus, whichever counter holds it, becomes a discard.
                fetch_pc    <= i_flush_pc & ~XLEN'(3);
                discard     <= discard + DW'(outstanding) + DW'(ack) - DW'(i_inst_response_valid);
                outstanding <= '0;
                count       <= '0;
                q_head      <= '0;
                q_tail      <= '0;
                t_head      <= '0;
                t_tail      <= '0;
            end else begin
                if (ack) begin
                    fetch_pc    <= fetch_pc + XLEN'(4);
                    tag[t_tail] <= fetch_pc;
                    t_tail      <= t_tail + 1'b1;
                end
                if (i_inst_response_valid && discard != '0)
                    discard <= discard - 1'b1;
                if (push) begin
                    q_pc[q_tail]   <= tag[t_head];
                    q_inst[q_tail] <= i_inst_response_data;
                    q_tail         <= q_tail + 1'b1;
                    t_head         <= t_head + 1'b1;
                end
                if (pop)
                    q_head <= q_head + 1'b1;
                outstanding <= outstanding + CW'(ack) - CW'(push);
                count       <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
